// File: rtl/servant_uart_tx.sv
// servant_uart_tx: 8N1 UART transmitter behind a two-register bus port (DATA/STATUS).
// Define SERVANT_UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
//
// state | meaning
// IDLE  | line high, waiting for a stored byte
// START | start bit (line low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); chains directly to START when more data is stored

module servant_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_wb_adr,
  input  logic [7:0]  i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          ovf_q, ovf_d;

  logic       req, wr_en, stat_rd;
  logic       push, pop, ovf_set;
  logic       full, empty, busy;
  logic [7:0] head;

`ifdef SERVANT_UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // When full, a simultaneous push lands in the slot being popped this edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_wb_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic       unused_fifo_depth;

  assign unused_fifo_depth = (FIFO_DEPTH > 0);
  assign full  = hold_vld_q;
  assign empty = !hold_vld_q;
  assign head  = hold_q;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (push) begin
      hold_d     = i_wb_dat;
      hold_vld_d = 1'b1;
    end else if (pop) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  assign busy = !empty || (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          cnt_d   = BIT_LAST;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LAST;
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LAST;
          idx_d   = idx_q + 3'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = head;
            cnt_d   = BIT_LAST;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  // A full store still accepts a write when the shifter pops on the same edge.
  always_comb begin
    req     = i_wb_cyc && !ack_q;
    wr_en   = req && i_wb_we && !i_wb_adr;
    stat_rd = req && !i_wb_we && i_wb_adr;
    push    = wr_en && (!full || pop);
    ovf_set = wr_en && full && !pop;
    ack_d   = req;
    rdt_d   = stat_rd ? {29'd0, ovf_q, full, busy} : 32'd0;
    ovf_d   = ovf_set || (ovf_q && !stat_rd);
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_tx     = tx_q;
  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_irq    = !busy;

endmodule

// File: tb/tb_servant_uart_tx.sv
// Directed bench for servant_uart_tx with CLKS_PER_BIT=4; a serial receiver decodes o_tx.
module tb_servant_uart_tx;
  localparam int CPB = 4;
`ifdef SERVANT_UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adr = 1'b0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic [7:0]  dat = 8'h00;
  logic [31:0] rdt;
  logic        ack, tx, irq;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  servant_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat),
    .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack),
    .o_tx(tx), .o_irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // serial receiver: samples each bit at its centre on the falling clock edge
  logic       rx_act = 1'b0;
  int         rx_ph = 0;
  int         rx_k = 0;
  int         rx_err = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];
  int         rx_start[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_ph = 0;
        rx_start.push_back(cyc_cnt);
      end
    end else begin
      rx_ph++;
      if (rx_ph % CPB == CPB / 2) begin
        rx_k = rx_ph / CPB;
        if (rx_k == 0) begin
          if (tx !== 1'b0) rx_err++;
        end else if (rx_k <= 8) begin
          rx_sh = {tx, rx_sh[7:1]};
        end else begin
          if (tx !== 1'b1) rx_err++;
          rx_q.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic bus(input logic w, input logic a, input logic [7:0] d,
                     output logic [31:0] r, output logic k);
    @(negedge clk);
    cyc = 1'b1; we = w; adr = a; dat = d;
    @(posedge clk);
    @(negedge clk);
    r = rdt; k = ack;
    cyc = 1'b0; we = 1'b0; adr = 1'b0;
  endtask

  task automatic wait_rx(input int n, output logic ok);
    for (int c = 0; c < 12 * CPB * n + 50 && rx_q.size() < n; c++) @(negedge clk);
    ok = (rx_q.size() >= n);
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_start.delete();
  endtask

  task automatic test_reset();
    logic [31:0] r; logic a;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", ack); end
    total++; if (rdt !== 32'd0) begin bad++; $display("FAIL reset_rdt got=%h want=0", rdt); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL reset_irq got=%b want=1", irq); end
    rst_n = 1'b1;
    bus(1'b0, 1'b1, 8'h00, r, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL reset_rd_ack got=%b want=1", a); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_status got=%h want=0", r); end
  endtask

  task automatic test_ack();
    logic exp_ack;
    @(negedge clk);
    cyc = 1'b1; we = 1'b0; adr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_ack = (i % 2 == 0);
      total++;
      if (ack !== exp_ack) begin bad++; $display("FAIL ack_pulse i=%0d got=%b want=%b", i, ack, exp_ack); end
    end
    cyc = 1'b0; adr = 1'b0;
    @(negedge clk);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL ack_idle got=%b want=0", ack); end
  endtask

  task automatic test_single_frame();
    logic [31:0] r; logic a; logic [7:0] b; logic exp_tx;
    rx_clear();
    b = 8'h55;
    bus(1'b1, 1'b0, b, r, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL single_ack got=%b want=1", a); end
    total++; if (tx !== 1'b1 || irq !== 1'b0) begin bad++; $display("FAIL single_pre tx=%b irq=%b want tx=1 irq=0", tx, irq); end
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      if (i <= 4) exp_tx = 1'b0;
      else if (i <= 36) exp_tx = b[(i - 5) / CPB];
      else exp_tx = 1'b1;
      total++;
      if (tx !== exp_tx) begin bad++; $display("FAIL single_line cycle=%0d got=%b want=%b", i, tx, exp_tx); end
      if (i == 40 || i == 41) begin
        total++;
        if (irq !== (i == 41)) begin bad++; $display("FAIL single_irq cycle=%0d got=%b want=%b", i, irq, (i == 41)); end
      end
    end
    bus(1'b0, 1'b1, 8'h00, r, a);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL single_status got=%h want=0", r); end
    total++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin bad++; $display("FAIL single_rx count=%0d want 1 byte 55", rx_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic a; logic ok;
    rx_clear();
    for (int i = 0; i <= CAP; i++) bus(1'b1, 1'b0, 8'(i + 1), r, a);
    wait_rx(CAP + 1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_timeout got=%0d bytes want=%0d", rx_q.size(), CAP + 1); end
    for (int i = 0; i <= CAP && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== 8'(i + 1)) begin bad++; $display("FAIL b2b_byte i=%0d got=%h want=%h", i, rx_q[i], 8'(i + 1)); end
    end
    for (int i = 0; i + 1 < rx_start.size(); i++) begin
      total++;
      if (rx_start[i + 1] - rx_start[i] != 10 * CPB) begin
        bad++; $display("FAIL b2b_gap i=%0d got=%0d want=%0d", i, rx_start[i + 1] - rx_start[i], 10 * CPB);
      end
    end
    repeat (4) @(negedge clk);
    bus(1'b0, 1'b1, 8'h00, r, a);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL b2b_status got=%h want=0", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; logic a; logic ok;
    rx_clear();
    for (int i = 0; i <= CAP + 1; i++) begin
      bus(1'b1, 1'b0, 8'h10 + 8'(i), r, a);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL ovf_wr_ack i=%0d got=%b want=1", i, a); end
    end
    bus(1'b0, 1'b0, 8'h00, r, a);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL data_read got=%h want=0", r); end
    bus(1'b0, 1'b1, 8'h00, r, a);
    total++; if (r !== 32'h7) begin bad++; $display("FAIL ovf_status1 got=%h want=7", r); end
    bus(1'b0, 1'b1, 8'h00, r, a);
    total++; if (r !== 32'h3) begin bad++; $display("FAIL ovf_status2 got=%h want=3", r); end
    wait_rx(CAP + 1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ovf_timeout got=%0d bytes want=%0d", rx_q.size(), CAP + 1); end
    repeat (20 * CPB) @(negedge clk);
    total++; if (rx_q.size() != CAP + 1) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", rx_q.size(), CAP + 1); end
    for (int i = 0; i <= CAP && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL ovf_byte i=%0d got=%h want=%h", i, rx_q[i], 8'h10 + 8'(i)); end
    end
    bus(1'b0, 1'b1, 8'h00, r, a);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL ovf_status3 got=%h want=0", r); end
  endtask

  task automatic test_full_pop();
    logic [31:0] r; logic a; logic ok; int e0;
    rx_clear();
    bus(1'b1, 1'b0, 8'h30, r, a);
    e0 = cyc_cnt;
    for (int i = 1; i <= CAP; i++) bus(1'b1, 1'b0, 8'h30 + 8'(i), r, a);
    while (cyc_cnt < e0 + 39) @(negedge clk);
    bus(1'b1, 1'b0, 8'h3F, r, a);
    bus(1'b0, 1'b1, 8'h00, r, a);
    total++; if (r !== 32'h3) begin bad++; $display("FAIL fullpop_status got=%h want=3", r); end
    wait_rx(CAP + 2, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL fullpop_timeout got=%0d bytes want=%0d", rx_q.size(), CAP + 2); end
    for (int i = 0; i < CAP + 2 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== ((i == CAP + 1) ? 8'h3F : 8'h30 + 8'(i))) begin
        bad++; $display("FAIL fullpop_byte i=%0d got=%h want=%h", i, rx_q[i], (i == CAP + 1) ? 8'h3F : 8'h30 + 8'(i));
      end
    end
  endtask

  task automatic test_status_write();
    logic [31:0] r; logic a; logic low_seen;
    rx_clear();
    repeat (4) @(negedge clk);
    bus(1'b1, 1'b1, 8'hFF, r, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL stwr_ack got=%b want=1", a); end
    low_seen = 1'b0;
    repeat (10) begin @(negedge clk); if (tx !== 1'b1) low_seen = 1'b1; end
    total++; if (low_seen !== 1'b0) begin bad++; $display("FAIL stwr_line got=low want=high"); end
    bus(1'b0, 1'b1, 8'h00, r, a);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL stwr_status got=%h want=0", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic a; logic low_seen; int e0;
    rx_clear();
    bus(1'b1, 1'b0, 8'hA5, r, a);
    e0 = cyc_cnt;
    while (cyc_cnt < e0 + 18) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rstmid_bit3 got=%b want=0", tx); end
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b want=1", tx); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rstmid_irq got=%b want=1", irq); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus(1'b0, 1'b1, 8'h00, r, a);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL rstmid_status got=%h want=0", r); end
    low_seen = 1'b0;
    repeat (60) begin @(negedge clk); if (tx !== 1'b1) low_seen = 1'b1; end
    total++; if (low_seen !== 1'b0 || rx_q.size() != 0) begin bad++; $display("FAIL rstmid_residual got=%0d bytes want=0", rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_status_write();
    test_reset_mid();
    total++; if (rx_err != 0) begin bad++; $display("FAIL framing got=%0d errors want=0", rx_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
